// File: rtl/hit_power_controller_pkg.sv
// Shared game definitions for the shot/power logic: FSM states, power ceiling
// and the fixed-point scale of the aim direction vectors.
package hit_power_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CHARGE,
    S_FIRE,
    S_COOLDOWN
  } hit_state_e;

  localparam int unsigned MAX_POWER_DEFAULT = 15;

  // Unit vector magnitudes at 0, 22.5, 45 and 67.5 degrees, scaled by VEC_SCALE.
  localparam int VEC_SCALE = 64;
  localparam int VEC_NEAR  = 59;
  localparam int VEC_DIAG  = 45;
  localparam int VEC_FAR   = 24;

endpackage

// File: rtl/hit_power_controller_aim_vector_lut.sv
// Combinational 16-direction aim table: aim_dir*22.5 deg (CCW from +X) to a
// signed unit vector scaled by 64, built from one quadrant plus rotation.
module aim_vector_lut
  import hit_power_controller_pkg::*;
(
  input  logic [3:0]        aim_dir,
  output logic signed [7:0] vec_x,
  output logic signed [7:0] vec_y
);

  logic signed [7:0] mag_cos;
  logic signed [7:0] mag_sin;

  function automatic logic signed [7:0] quad_mag(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'(VEC_SCALE);
      3'd1:    return 8'(VEC_NEAR);
      3'd2:    return 8'(VEC_DIAG);
      3'd3:    return 8'(VEC_FAR);
      default: return 8'sd0;
    endcase
  endfunction

  // Each 90-degree quadrant is the first quadrant rotated: (x,y) -> (-y,x).
  always_comb begin
    mag_cos = quad_mag({1'b0, aim_dir[1:0]});
    mag_sin = quad_mag(3'd4 - {1'b0, aim_dir[1:0]});
    vec_x   = mag_cos;
    vec_y   = mag_sin;
    case (aim_dir[3:2])
      2'd0: begin vec_x = mag_cos;  vec_y = mag_sin;  end
      2'd1: begin vec_x = -mag_sin; vec_y = mag_cos;  end
      2'd2: begin vec_x = -mag_cos; vec_y = -mag_sin; end
      default: begin vec_x = mag_sin; vec_y = -mag_cos; end
    endcase
  end

endmodule

// File: rtl/hit_power_controller.sv
// Cue shot controller: charges a power level while the key is held, fires one
// whiteBallMove pulse with a launch velocity on release, then waits for turn end.
module hit_power_controller
  import hit_power_controller_pkg::*;
#(
  parameter int unsigned MAX_POWER       = MAX_POWER_DEFAULT,
  parameter int unsigned FRAMES_PER_STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               hitEnable,
  input  logic               hitKeyN,
  input  logic [3:0]         aimDir,
  output logic               whiteBallMove,
  output logic signed [10:0] shotSpeedX,
  output logic signed [10:0] shotSpeedY,
  output logic [3:0]         powerLevel,
  output logic               charging
);

  localparam int unsigned   FW         = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);
  localparam logic [3:0]    POWER_MAX  = 4'(MAX_POWER);

  hit_state_e          state_q, state_d;
  logic [3:0]          power_q, power_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic signed [10:0]  speed_x_q, speed_x_d;
  logic signed [10:0]  speed_y_q, speed_y_d;
  logic signed [7:0]   vec_x;
  logic signed [7:0]   vec_y;

  aim_vector_lut u_aim_lut (
    .aim_dir (aimDir),
    .vec_x   (vec_x),
    .vec_y   (vec_y)
  );

  // Power is at most 15 and the vector at most 64, so 11 bits never overflow.
  function automatic logic signed [10:0] scale_vec(input logic [3:0] pwr,
                                                   input logic signed [7:0] vec);
    logic signed [10:0] p;
    logic signed [10:0] v;
    p = $signed({7'b0, pwr});
    v = {{3{vec[7]}}, vec};
    return p * v;
  endfunction

  always_comb begin
    state_d   = state_q;
    power_d   = power_q;
    frame_d   = frame_q;
    speed_x_d = speed_x_q;
    speed_y_d = speed_y_q;
    case (state_q)
      S_IDLE: begin
        if (hitEnable && hitKeyN) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!hitEnable) begin
          state_d = S_IDLE;
        end else if (!hitKeyN) begin
          state_d = S_CHARGE;
          power_d = 4'd1;
          frame_d = '0;
        end
      end
      S_CHARGE: begin
        // Abort beats release, and release beats a coincident frame tick.
        if (!hitEnable) begin
          state_d = S_IDLE;
          power_d = 4'd0;
          frame_d = '0;
        end else if (hitKeyN) begin
          state_d   = S_FIRE;
          speed_x_d = scale_vec(power_q, vec_x);
          speed_y_d = scale_vec(power_q, vec_y);
        end else if (startOfFrame) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            if (power_q < POWER_MAX) power_d = power_q + 4'd1;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      S_FIRE: begin
        state_d = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (!hitEnable) begin
          state_d = S_IDLE;
          power_d = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        power_d = 4'd0;
        frame_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      power_q   <= 4'd0;
      frame_q   <= '0;
      speed_x_q <= '0;
      speed_y_q <= '0;
    end else begin
      state_q   <= state_d;
      power_q   <= power_d;
      frame_q   <= frame_d;
      speed_x_q <= speed_x_d;
      speed_y_q <= speed_y_d;
    end
  end

  assign whiteBallMove = (state_q == S_FIRE);
  assign charging      = (state_q == S_CHARGE);
  assign powerLevel    = power_q;
  assign shotSpeedX    = speed_x_q;
  assign shotSpeedY    = speed_y_q;

endmodule
